// File: rtl/gate_arb_311.sv
// Round-robin arbiter sharing one registered bitwise gate unit (NOT/OR/AND/NAND/NOR/XOR/XNOR/BUF) among four requesters.
// Latency: request sampled in IDLE at edge k, result/ack valid for the single cycle between edges k+1 and k+2.
// Backpressure: requesters hold req until ack; one service per 3 cycles, losers stay pending, no req->output comb path.
module gate_arb_311 #(
  parameter int WIDTH = 4
) (
  input  logic               clk_311,
  input  logic               rst_n_311,
  input  logic [3:0]         req_311,
  input  logic [11:0]        op_311,
  input  logic [4*WIDTH-1:0] a_311,
  input  logic [4*WIDTH-1:0] b_311,
  output logic [3:0]         ack_311,
  output logic               rsp_valid_311,
  output logic [1:0]         rsp_id_311,
  output logic [WIDTH-1:0]   result_311,
  output logic               busy_311
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_NOT  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_ptr;
  logic [1:0]       r_gnt_id;
  logic [1:0]       r_rsp_id;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;

  logic [1:0]       w_idx [4];
  logic             w_found;
  logic [1:0]       w_winner;
  logic [2:0]       w_sel_op;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic [WIDTH-1:0] w_alu;

  // Candidate indices in search order: ptr, ptr+1, ptr+2, ptr+3 (mod 4 via 2-bit wrap).
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_idx[k] = r_ptr + 2'(k);
    end
  end

  // Round-robin pick: scan from the far end so the candidate closest to ptr wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (req_311[w_idx[k]]) begin
        w_found  = 1'b1;
        w_winner = w_idx[k];
      end
    end
  end

  // Mux the winner's opcode and operands for capture at grant.
  always_comb begin
    w_sel_op = op_311[3*int'(w_winner) +: 3];
    w_sel_a  = a_311[WIDTH*int'(w_winner) +: WIDTH];
    w_sel_b  = b_311[WIDTH*int'(w_winner) +: WIDTH];
  end

  // Bitwise gate function on the latched operands only.
  always_comb begin
    w_alu = r_a;
    case (r_op)
      OP_NOT:  w_alu = ~r_a;
      OP_OR:   w_alu = r_a | r_b;
      OP_AND:  w_alu = r_a & r_b;
      OP_NAND: w_alu = ~(r_a & r_b);
      OP_NOR:  w_alu = ~(r_a | r_b);
      OP_XOR:  w_alu = r_a ^ r_b;
      OP_XNOR: w_alu = ~(r_a ^ r_b);
      default: w_alu = r_a;
    endcase
  end

  // State register.
  always_ff @(posedge clk_311 or negedge rst_n_311) begin
    if (!rst_n_311) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: IDLE waits for any request, EXEC and RESP are one cycle each.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: capture at grant, evaluate in EXEC, advance ptr only on a completed service.
  always_ff @(posedge clk_311 or negedge rst_n_311) begin
    if (!rst_n_311) begin
      r_ptr    <= 2'd0;
      r_gnt_id <= 2'd0;
      r_rsp_id <= 2'd0;
      r_op     <= 3'd0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt_id <= w_winner;
            r_op     <= w_sel_op;
            r_a      <= w_sel_a;
            r_b      <= w_sel_b;
          end
        end
        S_EXEC: begin
          r_result <= w_alu;
          r_rsp_id <= r_gnt_id;
        end
        S_RESP: begin
          r_ptr <= r_gnt_id + 2'd1;
        end
        default: begin
          r_ptr <= r_ptr;
        end
      endcase
    end
  end

  // Handshake outputs decoded purely from registered state.
  always_comb begin
    rsp_valid_311 = (r_state == S_RESP);
    busy_311      = (r_state != S_IDLE);
    ack_311       = rsp_valid_311 ? (4'b0001 << r_gnt_id) : 4'b0000;
  end

  assign rsp_id_311 = r_rsp_id;
  assign result_311 = r_result;

endmodule
